// File: rtl/rx32_thread_pkg.sv
// Shared types and sizing for the Rx32 hardware-thread scheduler.
// Contents:
//   NUM_THREADS, TID_W, PIPE_DEPTH - default sizing of the barrel core
//   tid_t                          - hardware thread identifier
//   tid_entry_t                    - {valid, tid} record carried down the tid pipeline
package rx32_thread_pkg;

    localparam int unsigned NUM_THREADS = 5;
    localparam int unsigned TID_W       = 3;
    localparam int unsigned PIPE_DEPTH  = 4;

    typedef logic [TID_W-1:0] tid_t;

    typedef struct packed {
        logic valid;
        tid_t tid;
    } tid_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker over the eligible-thread mask.
// Ports:
//   eligible   in  NUM_THREADS  threads allowed to issue this cycle
//   last_ptr   in  TID_W        most recently issued thread (searched last)
//   pick       out TID_W        first eligible thread strictly after last_ptr, wrapping;
//                               last_ptr when nothing is eligible
//   pick_found out 1            a pick exists
module rr_arbiter #(
    parameter int unsigned NUM_THREADS = 5,
    parameter int unsigned TID_W       = 3
) (
    input  logic [NUM_THREADS-1:0] eligible,
    input  logic [TID_W-1:0]       last_ptr,
    output logic [TID_W-1:0]       pick,
    output logic                   pick_found
);

    // One extra bit so last_ptr + offset cannot overflow before the wrap.
    localparam int unsigned SUM_W = TID_W + 1;

    logic [SUM_W-1:0] cand;

    // Offsets 1..NUM_THREADS visit every thread once, last_ptr itself last.
    // last_ptr is always < NUM_THREADS, so a single subtract performs the modulo.
    always_comb begin
        pick       = last_ptr;
        pick_found = 1'b0;
        cand       = '0;
        for (int unsigned off = 1; off <= NUM_THREADS; off++) begin
            cand = SUM_W'(last_ptr) + SUM_W'(off);
            if (cand >= SUM_W'(NUM_THREADS)) begin
                cand = cand - SUM_W'(NUM_THREADS);
            end
            if (!pick_found && eligible[cand[TID_W-1:0]]) begin
                pick       = cand[TID_W-1:0];
                pick_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// Hardware-thread scheduler for the Rx32 barrel core: round-robin thread pick,
// PC register bank read/write selects, and a valid-tagged tid pipeline.
// Ports:
//   clk, reset                     clock; asynchronous active-high reset
//   stall                          freezes fetch and the tid pipeline
//   thread_active                  per-thread enable mask
//   block_valid/block_tid          set a thread's blocked bit (next cycle)
//   unblock_valid/unblock_tid      clear a thread's blocked bit (next cycle)
//   redirect_valid/redirect_tid    redirect that thread's PC; steals the write port
//   sel_read                       PC bank read select (thread being fetched)
//   sel_write, pc_en               PC bank write select / enable
//   pc_src_redirect                1 = redirect target, 0 = PC+4
//   fetch_valid                    an instruction is fetched for sel_read
//   wb_valid/wb_tid                owner of the instruction leaving the last tracked stage
// The bank-facing outputs are combinational: the bank samples them in the same cycle.
// The pipeline entries use the package tid_t, so TID_W must match the package value.
module thread_scheduler #(
    parameter int unsigned NUM_THREADS = rx32_thread_pkg::NUM_THREADS,
    parameter int unsigned TID_W       = rx32_thread_pkg::TID_W,
    parameter int unsigned PIPE_DEPTH  = rx32_thread_pkg::PIPE_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic [NUM_THREADS-1:0] thread_active,
    input  logic                   block_valid,
    input  logic [TID_W-1:0]       block_tid,
    input  logic                   unblock_valid,
    input  logic [TID_W-1:0]       unblock_tid,
    input  logic                   redirect_valid,
    input  logic [TID_W-1:0]       redirect_tid,
    output logic [TID_W-1:0]       sel_read,
    output logic [TID_W-1:0]       sel_write,
    output logic                   pc_en,
    output logic                   pc_src_redirect,
    output logic                   fetch_valid,
    output logic                   wb_valid,
    output logic [TID_W-1:0]       wb_tid
);

    import rx32_thread_pkg::tid_t;
    import rx32_thread_pkg::tid_entry_t;

    logic [TID_W-1:0]       last_ptr;
    logic [NUM_THREADS-1:0] blocked;
    logic [NUM_THREADS-1:0] blocked_next;
    logic [NUM_THREADS-1:0] eligible;
    logic [TID_W-1:0]       pick;
    logic                   pick_found;
    logic                   redirect_ok;
    logic                   block_ok;
    logic                   unblock_ok;
    tid_entry_t             pipe      [PIPE_DEPTH];
    tid_entry_t             pipe_next [PIPE_DEPTH];

    // Requests naming a nonexistent thread are dropped.
    assign redirect_ok = redirect_valid && (32'(redirect_tid) < NUM_THREADS);
    assign block_ok    = block_valid    && (32'(block_tid)    < NUM_THREADS);
    assign unblock_ok  = unblock_valid  && (32'(unblock_tid)  < NUM_THREADS);

    assign eligible = thread_active & ~blocked;

    rr_arbiter #(
        .NUM_THREADS(NUM_THREADS),
        .TID_W      (TID_W)
    ) u_rr_arbiter (
        .eligible  (eligible),
        .last_ptr  (last_ptr),
        .pick      (pick),
        .pick_found(pick_found)
    );

    // Read select, fetch qualification and write-port mux (redirect > fetch > idle).
    always_comb begin
        sel_read        = (pick_found && !reset) ? pick : last_ptr;
        fetch_valid     = pick_found && !stall && !redirect_ok && !reset;
        sel_write       = sel_read;
        pc_en           = 1'b0;
        pc_src_redirect = 1'b0;
        if (reset) begin
            pc_en = 1'b0;
        end else if (redirect_ok) begin
            sel_write       = redirect_tid;
            pc_en           = 1'b1;
            pc_src_redirect = 1'b1;
        end else if (fetch_valid) begin
            pc_en = 1'b1;
        end
    end

    // Clear first, then set, so a same-cycle block of the same thread wins.
    always_comb begin
        blocked_next = blocked;
        if (unblock_ok) begin
            blocked_next[unblock_tid] = 1'b0;
        end
        if (block_ok) begin
            blocked_next[block_tid] = 1'b1;
        end
    end

    // Tid pipeline: shift when not stalled, then flush the redirected thread.
    always_comb begin
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            pipe_next[i] = pipe[i];
        end
        if (!stall) begin
            pipe_next[0].valid = fetch_valid;
            pipe_next[0].tid   = tid_t'(sel_read);
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipe_next[i] = pipe[i-1];
            end
        end
        if (redirect_ok) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                if (pipe_next[i].tid == tid_t'(redirect_tid)) begin
                    pipe_next[i].valid = 1'b0;
                end
            end
        end
    end

    // State registers; last_ptr resets to the top thread so thread 0 is picked first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_ptr <= TID_W'(NUM_THREADS - 1);
            blocked  <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            if (fetch_valid) begin
                last_ptr <= pick;
            end
            blocked <= blocked_next;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe[i] <= pipe_next[i];
            end
        end
    end

    assign wb_valid = pipe[PIPE_DEPTH-1].valid;
    assign wb_tid   = TID_W'(pipe[PIPE_DEPTH-1].tid);

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed self-checking bench for thread_scheduler.
module tb_thread_scheduler;

    localparam int unsigned NUM_THREADS = 5;
    localparam int unsigned TID_W       = 3;
    localparam int unsigned PIPE_DEPTH  = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   stall = 1'b0;
    logic [NUM_THREADS-1:0] thread_active = '1;
    logic                   block_valid = 1'b0;
    logic [TID_W-1:0]       block_tid = '0;
    logic                   unblock_valid = 1'b0;
    logic [TID_W-1:0]       unblock_tid = '0;
    logic                   redirect_valid = 1'b0;
    logic [TID_W-1:0]       redirect_tid = '0;
    logic [TID_W-1:0]       sel_read;
    logic [TID_W-1:0]       sel_write;
    logic                   pc_en;
    logic                   pc_src_redirect;
    logic                   fetch_valid;
    logic                   wb_valid;
    logic [TID_W-1:0]       wb_tid;

    int errors = 0;
    int checks = 0;

    // Hand-computed expectation tables (index = cycle after reset release).
    int exp_b   [16] = '{0, 1, 3, 4, 0, 1, 3, 4, 0, 1, 2, 3, 4, 0, 1, 3};
    int exp_c   [11] = '{0, 1, 2, 3, 3, 4, 0, 1, 2, 3, 4};
    int wbv_c   [11] = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 1};
    int wbt_c   [11] = '{0, 0, 0, 0, 0, 0, 2, 0, 3, 4, 0};
    int sel_d   [12] = '{0, 1, 2, 3, 4, 0, 0, 0, 0, 1, 2, 3};
    int fv_d    [12] = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
    int wbv_d   [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 1};
    int wbt_d   [12] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 0, 4};

    always #5 clk = ~clk;

    thread_scheduler #(
        .NUM_THREADS(NUM_THREADS),
        .TID_W      (TID_W),
        .PIPE_DEPTH (PIPE_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .thread_active  (thread_active),
        .block_valid    (block_valid),
        .block_tid      (block_tid),
        .unblock_valid  (unblock_valid),
        .unblock_tid    (unblock_tid),
        .redirect_valid (redirect_valid),
        .redirect_tid   (redirect_tid),
        .sel_read       (sel_read),
        .sel_write      (sel_write),
        .pc_en          (pc_en),
        .pc_src_redirect(pc_src_redirect),
        .fetch_valid    (fetch_valid),
        .wb_valid       (wb_valid),
        .wb_tid         (wb_tid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_ports(input string tag, input int sel, input int fv,
                               input int wsel, input int en, input int src);
        chk({tag, " sel_read"},        32'(sel_read),        32'(sel));
        chk({tag, " fetch_valid"},     32'(fetch_valid),     32'(fv));
        chk({tag, " sel_write"},       32'(sel_write),       32'(wsel));
        chk({tag, " pc_en"},           32'(pc_en),           32'(en));
        chk({tag, " pc_src_redirect"}, 32'(pc_src_redirect), 32'(src));
    endtask

    task automatic check_wb(input string tag, input int v, input int tid);
        chk({tag, " wb_valid"}, 32'(wb_valid), 32'(v));
        if (v != 0) begin
            chk({tag, " wb_tid"}, 32'(wb_tid), 32'(tid));
        end
    endtask

    // Returns 2 time units after the next rising edge; checks follow at +1.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        stall          = 1'b0;
        thread_active  = '1;
        block_valid    = 1'b0;
        unblock_valid  = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset values
        tick();
        #1;
        check_ports("reset", 4, 0, 4, 0, 0);
        check_wb("reset", 0, 0);
        tick();
        reset = 1'b0;

        // Plain round robin over all five threads
        for (int c = 0; c < 10; c++) begin
            #1;
            check_ports($sformatf("rr c%0d", c), c % 5, 1, c % 5, 1, 0);
            if (c >= 4) check_wb($sformatf("rr c%0d", c), 1, (c - 4) % 5);
            else        check_wb($sformatf("rr c%0d", c), 0, 0);
            tick();
        end

        // Block / unblock / same-cycle block+unblock of thread 2
        do_reset();
        for (int c = 0; c < 16; c++) begin
            block_valid   = (c == 1 || c == 12);
            block_tid     = 3'd2;
            unblock_valid = (c == 7 || c == 12);
            unblock_tid   = 3'd2;
            #1;
            check_ports($sformatf("blk c%0d", c), exp_b[c], 1, exp_b[c], 1, 0);
            if (c >= 4) check_wb($sformatf("blk c%0d", c), 1, exp_b[c-4]);
            else        check_wb($sformatf("blk c%0d", c), 0, 0);
            tick();
        end
        block_valid   = 1'b0;
        unblock_valid = 1'b0;

        // Redirect of thread 1 when thread 3 is next; out-of-range redirect ignored
        do_reset();
        for (int c = 0; c < 11; c++) begin
            redirect_valid = (c == 3 || c == 9);
            redirect_tid   = (c == 3) ? 3'd1 : 3'd6;
            #1;
            if (c == 3) check_ports($sformatf("redir c%0d", c), 3, 0, 1, 1, 1);
            else        check_ports($sformatf("redir c%0d", c), exp_c[c], 1, exp_c[c], 1, 0);
            check_wb($sformatf("redir c%0d", c), wbv_c[c], wbt_c[c]);
            tick();
        end
        redirect_valid = 1'b0;

        // Three-cycle stall with a redirect of thread 3 in the middle
        do_reset();
        for (int c = 0; c < 12; c++) begin
            stall          = (c >= 5 && c <= 7);
            redirect_valid = (c == 6);
            redirect_tid   = 3'd3;
            #1;
            if (c == 6) check_ports($sformatf("stall c%0d", c), 0, 0, 3, 1, 1);
            else        check_ports($sformatf("stall c%0d", c), sel_d[c], fv_d[c], sel_d[c], fv_d[c], 0);
            check_wb($sformatf("stall c%0d", c), wbv_d[c], wbt_d[c]);
            tick();
        end
        stall          = 1'b0;
        redirect_valid = 1'b0;

        // No active threads, then only thread 4 active
        do_reset();
        for (int c = 0; c < 8; c++) begin
            thread_active = (c < 2) ? 5'b00000 : 5'b10000;
            #1;
            if (c < 2) check_ports($sformatf("act c%0d", c), 4, 0, 4, 0, 0);
            else       check_ports($sformatf("act c%0d", c), 4, 1, 4, 1, 0);
            if (c >= 6) check_wb($sformatf("act c%0d", c), 1, 4);
            else        check_wb($sformatf("act c%0d", c), 0, 0);
            tick();
        end

        // Asynchronous reset mid-stream
        do_reset();
        for (int c = 0; c < 5; c++) begin
            #1;
            check_ports($sformatf("arst c%0d", c), c, 1, c, 1, 0);
            tick();
        end
        #1;
        check_ports("arst c5", 0, 1, 0, 1, 0);
        check_wb("arst c5", 1, 1);
        reset = 1'b1;
        #1;
        check_ports("arst during", 4, 0, 4, 0, 0);
        check_wb("arst during", 0, 0);
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_ports($sformatf("arst post c%0d", c), c, 1, c, 1, 0);
            if (c == 4) check_wb($sformatf("arst post c%0d", c), 1, 0);
            else        check_wb($sformatf("arst post c%0d", c), 0, 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
